// File: rtl/fpu_result_stage.sv
// FPU result stage: resolves the final result/exception code at acceptance, buffers
// entries in a 2-deep FIFO, and keeps sticky exception flags plus a saturating counter.
module fpu_result_stage #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [1:0]       FP_OPERATION,
  input  logic [7:0]       OP_A,
  input  logic [7:0]       OP_B,
  input  logic [7:0]       ARITH_RESULT,
  input  logic             OP_IS_EXCEPTION,
  input  logic [2:0]       FP_EXCE,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [7:0]       OUT_RESULT,
  output logic [2:0]       OUT_EXCE,
  input  logic             FLAG_CLR,
  output logic             FLAG_INVALID,
  output logic             FLAG_DIVZERO,
  output logic [CNT_W-1:0] EXCE_COUNT
);

  localparam logic [7:0]       QNAN     = 8'h7C;
  localparam logic [6:0]       INF_MAG  = 7'h78;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  // Entry layout is {result[7:0], exce[2:0]}; any exception other than zero-divide maps to qNaN.
  function automatic logic [10:0] resolve_entry(
    input logic       is_exc,
    input logic [2:0] code,
    input logic       sign_a,
    input logic       sign_b,
    input logic [7:0] arith
  );
    logic [10:0] entry;
    if (is_exc) begin
      case (code)
        3'd4:    entry = {sign_a ^ sign_b, INF_MAG, code};
        default: entry = {QNAN, code};
      endcase
    end else begin
      entry = {arith, 3'd0};
    end
    return entry;
  endfunction

  logic [1:0]       count_r;
  logic [10:0]      head_r;
  logic [10:0]      tail_r;
  logic             up_r;
  logic             inv_r;
  logic             dz_r;
  logic [CNT_W-1:0] cnt_r;

  logic             accept_s;
  logic             pop_s;
  logic [10:0]      new_entry_s;
  logic             inc_s;
  logic             set_inv_s;
  logic             set_dz_s;
  logic [CNT_W-1:0] cnt_next_s;
  logic             unused_s;

  assign unused_s = ^{FP_OPERATION, OP_A[6:0], OP_B[6:0]};

  assign IN_READY     = up_r & (count_r != 2'd2);
  assign OUT_VALID    = (count_r != 2'd0);
  assign OUT_RESULT   = head_r[10:3];
  assign OUT_EXCE     = head_r[2:0];
  assign FLAG_INVALID = inv_r;
  assign FLAG_DIVZERO = dz_r;
  assign EXCE_COUNT   = cnt_r;

  assign accept_s    = IN_VALID & IN_READY;
  assign pop_s       = OUT_VALID & OUT_READY;
  assign new_entry_s = resolve_entry(OP_IS_EXCEPTION, FP_EXCE, OP_A[7], OP_B[7], ARITH_RESULT);
  assign inc_s       = accept_s & OP_IS_EXCEPTION;
  assign set_inv_s   = inc_s & ((FP_EXCE == 3'd2) | (FP_EXCE == 3'd3));
  assign set_dz_s    = inc_s & (FP_EXCE == 3'd4);

  // Next counter value: a same-cycle increment beats the clear.
  always_comb begin
    cnt_next_s = cnt_r;
    if (inc_s) begin
      if (FLAG_CLR) begin
        cnt_next_s = CNT_ONE;
      end else if (cnt_r != CNT_MAX) begin
        cnt_next_s = cnt_r + CNT_ONE;
      end else begin
        cnt_next_s = cnt_r;
      end
    end else if (FLAG_CLR) begin
      cnt_next_s = CNT_ZERO;
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Acceptance enable: stays low through reset and rises on the first edge after release.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      up_r <= 1'b0;
    end else begin
      up_r <= 1'b1;
    end
  end

  // Two-slot FIFO kept as head/tail registers so the output is always a register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count_r <= 2'd0;
      head_r  <= 11'd0;
      tail_r  <= 11'd0;
    end else begin
      case ({accept_s, pop_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            head_r <= new_entry_s;
          end else begin
            tail_r <= new_entry_s;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          head_r  <= tail_r;
          count_r <= count_r - 2'd1;
        end
        2'b11: begin
          // Only reachable at occupancy 1: the incoming entry replaces the departing head.
          head_r <= new_entry_s;
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  // Sticky flags and saturating counter; a same-cycle set beats FLAG_CLR.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      inv_r <= 1'b0;
      dz_r  <= 1'b0;
      cnt_r <= CNT_ZERO;
    end else begin
      inv_r <= set_inv_s | (inv_r & ~FLAG_CLR);
      dz_r  <= set_dz_s | (dz_r & ~FLAG_CLR);
      cnt_r <= cnt_next_s;
    end
  end

endmodule
